// File: rtl/mem_resp_queue_if.sv
// Handshake bundle between EX/SRAM/WB and the memory-response queue.
// The master side is the environment; the slave side is the queue itself.
interface mem_resp_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int INFO_W = 32
);
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              push_valid;
  logic              push_ready;
  logic              push_is_load;
  logic [4:0]        push_ld_op;
  logic [OFF_W-1:0]  push_offset;
  logic [INFO_W-1:0] push_info;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;
  logic              pop_valid;
  logic              pop_ready;
  logic [31:0]       pop_data;
  logic [INFO_W-1:0] pop_info;
  logic              pop_is_load;
  logic              flush;
  logic              busy;
  logic [CNT_W-1:0]  outstanding;

  modport master (
    output push_valid, push_is_load, push_ld_op, push_offset, push_info,
    output data_ok, rdata, pop_ready, flush,
    input  push_ready, pop_valid, pop_data, pop_info, pop_is_load, busy, outstanding
  );

  modport slave (
    input  push_valid, push_is_load, push_ld_op, push_offset, push_info,
    input  data_ok, rdata, pop_ready, flush,
    output push_ready, pop_valid, pop_data, pop_info, pop_is_load, busy, outstanding
  );
endinterface

// File: rtl/mem_resp_queue.sv
// In-order queue of outstanding data-SRAM requests: captures responses, extends
// load data and hands results to WB; flushed requests have their late responses discarded.
module mem_resp_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int INFO_W = 32
) (
  input  logic            clk,
  input  logic            resetn,
  mem_resp_queue_if.slave q
);
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rsp_ptr_q, rsp_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [DEPTH-1:0] done_q;

  logic              is_load_q [DEPTH];
  logic [4:0]        ld_op_q   [DEPTH];
  logic [OFF_W-1:0]  offset_q  [DEPTH];
  logic [INFO_W-1:0] info_q    [DEPTH];
  logic [DATA_W-1:0] data_q    [DEPTH];

  logic push_acc, rsp_acc, rsp_drop, bypass, pop_fire;
  logic [CNT_W-1:0] outstanding;

  assign outstanding = count_q + discard_q;
  assign q.push_ready = ~q.flush & (outstanding < DEPTH_C);
  assign push_acc = q.push_valid & q.push_ready;

  // pend_q counts queued entries still waiting for their response.
  assign rsp_drop = q.data_ok & (discard_q != '0);
  assign rsp_acc  = q.data_ok & (discard_q == '0) & (pend_q != '0);
  assign bypass   = rsp_acc & (rsp_ptr_q == rd_ptr_q);

  assign q.pop_valid = ~q.flush & (count_q != '0) & (done_q[rd_ptr_q] | bypass);
  assign pop_fire = q.pop_valid & q.pop_ready;

  always_comb begin
    count_d   = count_q + CNT_W'(push_acc) - CNT_W'(pop_fire);
    pend_d    = pend_q + CNT_W'(push_acc) - CNT_W'(rsp_acc);
    discard_d = discard_q - CNT_W'(rsp_drop);
    wr_ptr_d  = wr_ptr_q + PTR_W'(push_acc);
    rsp_ptr_d = rsp_ptr_q + PTR_W'(rsp_acc);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop_fire);
    if (q.flush) begin
      // Entries completed this very cycle need no discard.
      count_d   = '0;
      pend_d    = '0;
      discard_d = discard_q - CNT_W'(rsp_drop) + pend_q - CNT_W'(rsp_acc);
      wr_ptr_d  = wr_ptr_q;
      rsp_ptr_d = wr_ptr_q;
      rd_ptr_d  = wr_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q  <= '0;
      rsp_ptr_q <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pend_q    <= '0;
      discard_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rsp_ptr_q <= rsp_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pend_q    <= pend_d;
      discard_q <= discard_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          done_q[gi] <= 1'b0;
        end else if (push_acc && wr_ptr_q == PTR_W'(gi)) begin
          done_q[gi] <= 1'b0;
        end else if (rsp_acc && rsp_ptr_q == PTR_W'(gi)) begin
          done_q[gi] <= 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (push_acc && wr_ptr_q == PTR_W'(gi)) begin
          is_load_q[gi] <= q.push_is_load;
          ld_op_q[gi]   <= q.push_ld_op;
          offset_q[gi]  <= q.push_offset;
          info_q[gi]    <= q.push_info;
        end
        if (rsp_acc && rsp_ptr_q == PTR_W'(gi)) begin
          data_q[gi] <= q.rdata;
        end
      end
    end
  endgenerate

  logic [DATA_W-1:0] head_raw;
  logic [31:0]       lane, sh, ext_data;
  logic [4:0]        head_op;
  logic [OFF_W-1:0]  head_off;

  assign head_raw = bypass ? q.rdata : data_q[rd_ptr_q];
  assign head_op  = ld_op_q[rd_ptr_q];
  assign head_off = offset_q[rd_ptr_q];

  generate
    if (DATA_W == 64) begin : g_lane64
      assign lane = head_off[2] ? head_raw[63:32] : head_raw[31:0];
    end else begin : g_lane32
      assign lane = head_raw[31:0];
    end
  endgenerate

  assign sh = lane >> {head_off[1:0], 3'b000};

  always_comb begin
    ext_data = '0;
    if (head_op[4])      ext_data = {{24{sh[7]}}, sh[7:0]};
    else if (head_op[3]) ext_data = {24'b0, sh[7:0]};
    else if (head_op[2]) ext_data = {{16{sh[15]}}, sh[15:0]};
    else if (head_op[1]) ext_data = {16'b0, sh[15:0]};
    else if (head_op[0]) ext_data = sh;
  end

  assign q.pop_data    = (q.pop_valid & is_load_q[rd_ptr_q]) ? ext_data : 32'b0;
  assign q.pop_info    = info_q[rd_ptr_q];
  assign q.pop_is_load = is_load_q[rd_ptr_q];
  assign q.busy        = (count_q != '0) | (discard_q != '0);
  assign q.outstanding = outstanding;
endmodule

// File: tb/tb_mem_resp_queue.sv
// Directed bench for mem_resp_queue: expected pops are queued at push time and
// checked by an independent monitor whenever WB accepts a head.
module tb_mem_resp_queue;
  localparam logic [4:0] LD_B = 5'b10000, LD_BU = 5'b01000, LD_H = 5'b00100,
                         LD_HU = 5'b00010, LD_W = 5'b00001;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] info;
    logic        is_load;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int total = 0;
  int bad = 0;
  exp_t sb[$];

  mem_resp_queue_if #(.DEPTH(4), .DATA_W(32), .INFO_W(32)) bus ();
  mem_resp_queue #(.DEPTH(4), .DATA_W(32), .INFO_W(32)) dut (
    .clk(clk), .resetn(resetn), .q(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every presented head must have an expectation; accepted heads are compared.
  always @(negedge clk) begin
    if (resetn && bus.pop_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop: got info 0x%08h expected no pop_valid", bus.pop_info);
      end else if (bus.pop_ready) begin
        exp_t e;
        e = sb.pop_front();
        $display("pop info=0x%08h data=0x%08h is_load=%0b", bus.pop_info, bus.pop_data, bus.pop_is_load);
        chk("pop_data", bus.pop_data, e.data);
        chk("pop_info", bus.pop_info, e.info);
        chk("pop_is_load", {31'b0, bus.pop_is_load}, {31'b0, e.is_load});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    bus.push_valid = 1'b0;
    bus.data_ok    = 1'b0;
    bus.flush      = 1'b0;
  endtask

  task automatic do_push(input logic ld, input logic [4:0] op, input logic [1:0] off,
                         input logic [31:0] info, input logic [31:0] expd, input logic track);
    bus.push_valid   = 1'b1;
    bus.push_is_load = ld;
    bus.push_ld_op   = op;
    bus.push_offset  = off;
    bus.push_info    = info;
    if (track) sb.push_back('{data: expd, info: info, is_load: ld});
  endtask

  task automatic respond(input logic [31:0] d);
    bus.data_ok = 1'b1;
    bus.rdata   = d;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_push_ready"}, {31'b0, bus.push_ready}, 32'd1);
    chk({tag, "_pop_valid"}, {31'b0, bus.pop_valid}, 32'd0);
    chk({tag, "_busy"}, {31'b0, bus.busy}, 32'd0);
    chk({tag, "_outstanding"}, {29'b0, bus.outstanding}, 32'd0);
    chk({tag, "_pop_data"}, bus.pop_data, 32'd0);
  endtask

  typedef struct packed {
    logic [4:0]  op;
    logic [1:0]  off;
    logic [31:0] expd;
  } ext_vec_t;

  ext_vec_t ext_tab[8] = '{
    '{LD_BU, 2'd0, 32'h0000_00A1}, '{LD_H,  2'd0, 32'hFFFF_F0A1},
    '{LD_HU, 2'd2, 32'h0000_8765}, '{LD_W,  2'd0, 32'h8765_F0A1},
    '{LD_B,  2'd0, 32'hFFFF_FFA1}, '{LD_BU, 2'd2, 32'h0000_0065},
    '{LD_H,  2'd2, 32'hFFFF_8765}, '{LD_HU, 2'd0, 32'h0000_F0A1}
  };

  initial begin
    bus.push_valid = 0; bus.push_is_load = 0; bus.push_ld_op = '0; bus.push_offset = '0;
    bus.push_info = '0; bus.data_ok = 0; bus.rdata = '0; bus.pop_ready = 0; bus.flush = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk_reset_outputs("reset");
    cyc();
    resetn = 1'b1;

    // Single load with same-cycle bypass
    bus.pop_ready = 1'b1;
    cyc(); do_push(1, LD_B, 2'd2, 32'h100, 32'hFFFF_FF80, 1);
    cyc();
    cyc(); respond(32'h0080_0000); #1;
    chk("single_bypass_valid", {31'b0, bus.pop_valid}, 32'd1);
    cyc(); #1;
    chk("single_outstanding", {29'b0, bus.outstanding}, 32'd0);

    // Back-to-back fill with WB stalled
    bus.pop_ready = 1'b0;
    cyc(); do_push(1, LD_W,  2'd0, 32'h200, 32'h1122_3344, 1);
    cyc(); do_push(0, 5'b0,  2'd0, 32'h201, 32'h0,         1);
    cyc(); do_push(1, LD_HU, 2'd2, 32'h202, 32'h0000_ABCD, 1);
    cyc(); do_push(1, LD_BU, 2'd1, 32'h203, 32'h0000_00FE, 1);
    cyc(); #1;
    chk("full_push_ready", {31'b0, bus.push_ready}, 32'd0);
    respond(32'h1122_3344);
    cyc(); respond(32'hCAFE_BABE);
    cyc(); respond(32'hABCD_0000);
    cyc(); respond(32'h0000_FE00);
    cyc(); #1;
    chk("full_outstanding", {29'b0, bus.outstanding}, 32'd4);
    chk("full_pop_valid", {31'b0, bus.pop_valid}, 32'd1);
    bus.pop_ready = 1'b1;
    cyc(); #1;
    chk("after_pop_push_ready", {31'b0, bus.push_ready}, 32'd1);
    repeat (3) cyc();
    #1;
    chk("drained_busy", {31'b0, bus.busy}, 32'd0);

    // Extension matrix
    foreach (ext_tab[i]) begin
      cyc(); do_push(1, ext_tab[i].op, ext_tab[i].off, 32'h300 + i, ext_tab[i].expd, 1);
      cyc(); respond(32'h8765_F0A1);
    end
    cyc();

    // Flush with 3 outstanding, none done
    repeat (3) begin
      cyc(); do_push(1, LD_W, 2'd0, 32'h4FF, 32'h0, 0);
    end
    cyc(); bus.flush = 1'b1; #1;
    chk("flush_push_ready", {31'b0, bus.push_ready}, 32'd0);
    chk("flush_pop_valid", {31'b0, bus.pop_valid}, 32'd0);
    cyc(); #1;
    chk("flush_outstanding", {29'b0, bus.outstanding}, 32'd3);
    chk("flush_busy", {31'b0, bus.busy}, 32'd1);
    chk("discard_push_ready", {31'b0, bus.push_ready}, 32'd1);
    do_push(1, LD_B, 2'd0, 32'h500, 32'hFFFF_FFFF, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(); respond(32'hDEAD_BEEF); #1;
      chk("discard_no_pop", {31'b0, bus.pop_valid}, 32'd0);
    end
    cyc(); #1;
    chk("post_discard_outstanding", {29'b0, bus.outstanding}, 32'd1);
    respond(32'h0000_00FF); #1;
    chk("post_discard_pop_valid", {31'b0, bus.pop_valid}, 32'd1);
    cyc();

    // Flush coinciding with the oldest entry's response
    cyc(); do_push(1, LD_W, 2'd0, 32'h600, 32'h0, 0);
    cyc(); do_push(1, LD_W, 2'd0, 32'h601, 32'h0, 0);
    cyc(); bus.flush = 1'b1; respond(32'h1234_5678); #1;
    chk("flush_rsp_pop_valid", {31'b0, bus.pop_valid}, 32'd0);
    cyc(); #1;
    chk("flush_rsp_outstanding", {29'b0, bus.outstanding}, 32'd1);
    respond(32'h9999_9999); #1;
    chk("flush_rsp_drop", {31'b0, bus.pop_valid}, 32'd0);
    cyc(); #1;
    chk("flush_rsp_idle", {31'b0, bus.busy}, 32'd0);

    // Asynchronous reset in the middle of a transaction
    bus.pop_ready = 1'b0;
    cyc(); do_push(1, LD_W, 2'd0, 32'h700, 32'h0, 0);
    cyc(); do_push(1, LD_W, 2'd0, 32'h701, 32'h0, 0);
    cyc(); respond(32'h0BAD_F00D); #1;
    chk("pre_reset_pop_valid", {31'b0, bus.pop_valid}, 32'd1);
    resetn = 1'b0;
    bus.data_ok = 1'b0;
    #1;
    chk_reset_outputs("async");
    cyc();
    resetn = 1'b1;
    bus.pop_ready = 1'b1;
    cyc(); #1;
    chk("final_outstanding", {29'b0, bus.outstanding}, 32'd0);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
